// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: ROM/RAM/debug-register decode with a fixed IDLE->ISSUE->RESP sequence.
// Define MEM_ARBITER_LOADER_EN to add requester 1 (loader) and round-robin arbitration.
module mem_arbiter #(
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE = 32'h0000_1000,
  parameter logic [31:0] DBG_ADDR = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_err,
`ifdef MEM_ARBITER_LOADER_EN
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_err,
`endif
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        rom_cs,
  output logic        ram_cs,
  input  logic [31:0] rom_rdata,
  input  logic [31:0] ram_rdata,
  output logic [31:0] dbg
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [1:0] ROM_SEL = ROM_BASE[13:12];
  localparam logic [1:0] RAM_SEL = RAM_BASE[13:12];
  localparam logic [1:0] DBG_SEL = DBG_ADDR[13:12];

  state_t      state, state_next;
  logic        any_req, gnt_next, gnt, write_q;
  logic        sel_write;
  logic [31:0] sel_addr, sel_wdata;
  logic [31:0] m0_hold, rsp_data;
  logic        issue, resp, is_rom, is_ram, is_dbg, acc_err;
`ifdef MEM_ARBITER_LOADER_EN
  logic        last_gnt;
  logic [31:0] m1_hold;
`endif

  // Request selection; on a tie the requester not granted last wins
  always_comb begin
    any_req   = m0_req;
    gnt_next  = 1'b0;
    sel_write = m0_write;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
`ifdef MEM_ARBITER_LOADER_EN
    any_req  = m0_req | m1_req;
    gnt_next = m1_req & (~m0_req | ~last_gnt);
    if (gnt_next) begin
      sel_write = m1_write;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction latch; mem_addr/mem_wdata are driven straight from it
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt       <= 1'b0;
      write_q   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
`ifdef MEM_ARBITER_LOADER_EN
      last_gnt  <= 1'b1;
`endif
    end else if (state == IDLE && any_req) begin
      gnt       <= gnt_next;
      write_q   <= sel_write;
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
`ifdef MEM_ARBITER_LOADER_EN
      last_gnt  <= gnt_next;
`endif
    end
  end

  // Strobes are gated by reset so a reset cycle neither writes a device nor signals ready
  always_comb begin
    issue     = (state == ISSUE) && !reset;
    resp      = (state == RESP) && !reset;
    is_rom    = mem_addr[13:12] == ROM_SEL;
    is_ram    = !is_rom && (mem_addr[13:12] == RAM_SEL);
    is_dbg    = !is_rom && !is_ram && (mem_addr[13:12] == DBG_SEL);
    acc_err   = (is_rom && write_q) || !(is_rom || is_ram || is_dbg);
    rom_cs    = issue && is_rom && !write_q;
    ram_cs    = issue && is_ram;
    mem_write = issue && write_q && !acc_err;
    rsp_data  = acc_err ? 32'h0 : is_rom ? rom_rdata : is_ram ? ram_rdata : dbg;
    m0_ready  = resp && !gnt;
    m0_err    = m0_ready && acc_err;
    m0_rdata  = m0_ready ? rsp_data : m0_hold;
`ifdef MEM_ARBITER_LOADER_EN
    m1_ready  = resp && gnt;
    m1_err    = m1_ready && acc_err;
    m1_rdata  = m1_ready ? rsp_data : m1_hold;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dbg     <= 32'h0;
      m0_hold <= 32'h0;
`ifdef MEM_ARBITER_LOADER_EN
      m1_hold <= 32'h0;
`endif
    end else begin
      if (issue && is_dbg && write_q) dbg <= mem_wdata;
      if (m0_ready) m0_hold <= rsp_data;
`ifdef MEM_ARBITER_LOADER_EN
      if (m1_ready) m1_hold <= rsp_data;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with behavioural ROM/RAM models; loader tests run when
// MEM_ARBITER_LOADER_EN is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_write = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [31:0] m0_rdata;
  logic        m0_ready, m0_err;
`ifdef MEM_ARBITER_LOADER_EN
  logic        m1_req = 1'b0, m1_write = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [31:0] m1_rdata;
  logic        m1_ready, m1_err;
`endif
  logic [31:0] mem_addr, mem_wdata, dbg;
  logic        mem_write, rom_cs, ram_cs;
  logic [31:0] rom_rdata = '0, ram_rdata = '0;
  logic [31:0] ram [16];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
`ifdef MEM_ARBITER_LOADER_EN
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .rom_cs(rom_cs), .ram_cs(ram_cs), .rom_rdata(rom_rdata), .ram_rdata(ram_rdata),
    .dbg(dbg)
  );

  // ROM returns 0x0E07 + address; RAM is 16 words, both registered
  always @(posedge clk) begin
    if (rom_cs) rom_rdata <= 32'h0000_0E07 + mem_addr;
    if (ram_cs) begin
      if (mem_write) ram[mem_addr[5:2]] <= mem_wdata;
      ram_rdata <= ram[mem_addr[5:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs_rdata(input int m);
`ifdef MEM_ARBITER_LOADER_EN
    if (m == 1) return m1_rdata;
`endif
    return (m == 0) ? m0_rdata : 32'h0;
  endfunction

  function automatic logic obs_ready(input int m);
`ifdef MEM_ARBITER_LOADER_EN
    if (m == 1) return m1_ready;
`endif
    return (m == 0) ? m0_ready : 1'b0;
  endfunction

  function automatic logic obs_err(input int m);
`ifdef MEM_ARBITER_LOADER_EN
    if (m == 1) return m1_err;
`endif
    return (m == 0) ? m0_err : 1'b0;
  endfunction

  task automatic drive(input int m, input logic req, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_req = req; m0_write = wr; m0_addr = a; m0_wdata = d;
    end
`ifdef MEM_ARBITER_LOADER_EN
    if (m == 1) begin
      m1_req = req; m1_write = wr; m1_addr = a; m1_wdata = d;
    end
`endif
  endtask

  // One transaction, entered and left at posedge+1 with the FSM in IDLE
  task automatic txn(input string tag, input int m, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic e_rom, input logic e_ram,
                     input logic e_err, input logic chk_data, input logic [31:0] e_data);
    drive(m, 1'b1, wr, a, d);
    @(negedge clk);
    check({tag, ".ready_T"}, 32'(obs_ready(m)), 32'h0);
    @(negedge clk);
    check({tag, ".rom_cs"}, 32'(rom_cs), 32'(e_rom));
    check({tag, ".ram_cs"}, 32'(ram_cs), 32'(e_ram));
    check({tag, ".mem_write"}, 32'(mem_write), 32'(wr && !e_err));
    check({tag, ".mem_addr"}, mem_addr, a);
    check({tag, ".ready_T1"}, 32'(obs_ready(m)), 32'h0);
    @(negedge clk);
    check({tag, ".ready"}, 32'(obs_ready(m)), 32'h1);
    check({tag, ".err"}, 32'(obs_err(m)), 32'(e_err));
    if (chk_data) check({tag, ".rdata"}, obs_rdata(m), e_data);
    @(posedge clk); #1;
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst.ready", 32'(m0_ready), 32'h0);
    check("rst.err", 32'(m0_err), 32'h0);
    check("rst.rdata", m0_rdata, 32'h0);
    check("rst.dbg", dbg, 32'h0);
    check("rst.cs", 32'({rom_cs, ram_cs, mem_write}), 32'h0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;

    txn("rom_rd4", 0, 1'b0, 32'h0000_0004, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0E0B);
    txn("dbg_wr", 0, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("dbg_wr.dbg", dbg, 32'hCAFE_F00D);
    txn("dbg_rd", 0, 1'b0, 32'h0000_2000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
    txn("ram_wr", 0, 1'b1, 32'h0000_1008, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    txn("ram_rd", 0, 1'b0, 32'h0000_1008, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    txn("rom_wr", 0, 1'b1, 32'h0000_0010, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    txn("unm_rd", 0, 1'b0, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    txn("unm_wr", 0, 1'b1, 32'h0000_3004, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("unm_wr.dbg", dbg, 32'hCAFE_F00D);
    txn("full_addr", 0, 1'b0, 32'hABCD_1008, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);

    // Request dropped after the grant still completes
    drive(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("drop.rom_cs", 32'(rom_cs), 32'h1);
    @(negedge clk);
    check("drop.ready", 32'(m0_ready), 32'h1);
    check("drop.rdata", m0_rdata, 32'h0000_0E27);
    @(negedge clk);
    check("hold.ready", 32'(m0_ready), 32'h0);
    check("hold.rdata", m0_rdata, 32'h0000_0E27);
    @(posedge clk); #1;

    // Reset during ISSUE of a RAM write drops the transaction
    drive(0, 1'b1, 1'b1, 32'h0000_1010, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rstmid.ram_cs", 32'(ram_cs), 32'h0);
    check("rstmid.mem_write", 32'(mem_write), 32'h0);
    check("rstmid.ready", 32'(m0_ready), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rstmid.ready_after", 32'(m0_ready), 32'h0);
    check("rstmid.dbg", dbg, 32'h0);
    check("rstmid.rdata", m0_rdata, 32'h0);
    @(posedge clk); #1;
    txn("rstmid_rd", 0, 1'b0, 32'h0000_1010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    txn("dbg_rd0", 0, 1'b0, 32'h0000_2000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

`ifdef MEM_ARBITER_LOADER_EN
    // Both requesters continuously: m0 first after reset, then alternate every 3 cycles
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h0000_1008, 32'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("rr.m0_ready[%0d]", k), 32'(m0_ready), 32'(k == 2 || k == 8));
      check($sformatf("rr.m1_ready[%0d]", k), 32'(m1_ready), 32'(k == 5 || k == 11));
      if (k == 2 || k == 8) check($sformatf("rr.m0_rdata[%0d]", k), m0_rdata, 32'h0000_0E0F);
      if (k == 5 || k == 11) check($sformatf("rr.m1_rdata[%0d]", k), m1_rdata, 32'h1234_5678);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

    txn("m1_rom_wr", 1, 1'b1, 32'h0000_0010, 32'h7777_7777, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    txn("m1_unm_rd", 1, 1'b0, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    txn("m1_dbg_wr", 1, 1'b1, 32'h0000_2000, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("m1_dbg_wr.dbg", dbg, 32'h0000_0042);
    check("m1.m0_idle_ready", 32'(m0_ready), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
